// File: rtl/adder_fu_sched_pkg.sv
// Shared types and helpers for the adder functional-unit scheduler.
package adder_fu_sched_pkg;

    typedef enum logic [1:0] {
        MODE_4X16    = 2'd0,
        MODE_2X32    = 2'd1,
        MODE_ILLEGAL = 2'd2,
        MODE_1X64    = 2'd3
    } fu_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam int unsigned NUM_LANES    = 4;
    localparam int unsigned NUM_OPERANDS = 8;
    localparam int unsigned CNT_W        = 8;

    function automatic int unsigned mode_latency(fu_mode_e mode, int unsigned l16,
                                                 int unsigned l32, int unsigned l64);
        case (mode)
            MODE_4X16: return l16;
            MODE_2X32: return l32;
            MODE_1X64: return l64;
            default:   return 1;
        endcase
    endfunction

    function automatic logic mode_legal(fu_mode_e mode);
        return mode != MODE_ILLEGAL;
    endfunction

endpackage

// File: rtl/adder_fu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    logic [IW:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr < N, so ptr + i needs at most one wrap
            idx = (IW+1)'(ptr) + (IW+1)'(i);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!any && req[idx[IW-1:0]]) begin
                grant[idx[IW-1:0]] = 1'b1;
                grant_idx          = idx[IW-1:0];
                any                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_fu_sched.sv
// Shares one adder FU among NUM_REQ requesters; one op in flight, tagged response.
module adder_fu_sched
    import adder_fu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LAT_4X16 = 2,
    parameter int unsigned LAT_2X32 = 3,
    parameter int unsigned LAT_1X64 = 5
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_REQ-1:0]                             req_valid,
    output logic [NUM_REQ-1:0]                             req_ready,
    input  logic [NUM_REQ-1:0][1:0]                        req_mode,
    input  logic [NUM_REQ-1:0][NUM_OPERANDS-1:0][WIDTH-1:0] req_operands,
    output logic                                           rsp_valid,
    input  logic                                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]                     rsp_id,
    output logic [NUM_LANES-1:0][WIDTH-1:0]                rsp_sum,
    output logic                                           rsp_carry,
    output logic                                           rsp_err,
    output logic [NUM_OPERANDS-1:0][WIDTH-1:0]             fu_inputs,
    output logic [1:0]                                     fu_config,
    output logic                                           fu_on_off,
    input  logic [NUM_LANES-1:0][WIDTH-1:0]                fu_outputs,
    input  logic                                           fu_carry_out
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    sched_state_e                          state_q, state_d;
    logic [IW-1:0]                         rr_q, rr_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [NUM_OPERANDS-1:0][WIDTH-1:0]    fu_inputs_q, fu_inputs_d;
    logic [1:0]                            fu_config_q, fu_config_d;
    logic                                  fu_on_off_q, fu_on_off_d;
    logic                                  rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]                         rsp_id_q, rsp_id_d;
    logic [NUM_LANES-1:0][WIDTH-1:0]       rsp_sum_q, rsp_sum_d;
    logic                                  rsp_carry_q, rsp_carry_d;
    logic                                  rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               accept;
    fu_mode_e           sel_mode;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Grant is only offered while idle and out of reset
    assign req_ready = (state_q == IDLE && reset) ? arb_grant : '0;
    assign accept    = arb_any && state_q == IDLE && reset;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        fu_inputs_d = fu_inputs_q;
        fu_config_d = fu_config_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        sel_mode    = fu_mode_e'(req_mode[arb_idx]);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rr_d     = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    rsp_id_d = arb_idx;
                    if (mode_legal(sel_mode)) begin
                        fu_inputs_d = req_operands[arb_idx];
                        fu_config_d = req_mode[arb_idx];
                        cnt_d       = CNT_W'(mode_latency(sel_mode, LAT_4X16, LAT_2X32,
                                                          LAT_1X64) - 1);
                        state_d     = WAIT;
                    end else begin
                        rsp_sum_d   = '0;
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_sum_d   = fu_outputs;
                    rsp_carry_d = fu_carry_out;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        fu_on_off_d = (state_d == WAIT);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            fu_inputs_q <= '0;
            fu_config_q <= '0;
            fu_on_off_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            fu_inputs_q <= fu_inputs_d;
            fu_config_q <= fu_config_d;
            fu_on_off_q <= fu_on_off_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign fu_inputs = fu_inputs_q;
    assign fu_config = fu_config_q;
    assign fu_on_off = fu_on_off_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_adder_fu_sched.sv
// Bench for adder_fu_sched: behavioural adder FU plus reference sums and timing.
module tb_adder_fu_sched;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned LAT_4X16 = 2;
    localparam int unsigned LAT_2X32 = 3;
    localparam int unsigned LAT_1X64 = 5;

    typedef logic [7:0][WIDTH-1:0] ops_t;

    logic                             clk;
    logic                             reset;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0][1:0]          req_mode;
    logic [NUM_REQ-1:0][7:0][WIDTH-1:0] req_operands;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [1:0]                       rsp_id;
    logic [3:0][WIDTH-1:0]            rsp_sum;
    logic                             rsp_carry;
    logic                             rsp_err;
    logic [7:0][WIDTH-1:0]            fu_inputs;
    logic [1:0]                       fu_config;
    logic                             fu_on_off;
    logic [3:0][WIDTH-1:0]            fu_outputs;
    logic                             fu_carry_out;

    int checks = 0;
    int errors = 0;

    adder_fu_sched #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH),
        .LAT_4X16(LAT_4X16), .LAT_2X32(LAT_2X32), .LAT_1X64(LAT_1X64)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_operands(req_operands),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .fu_inputs(fu_inputs), .fu_config(fu_config), .fu_on_off(fu_on_off),
        .fu_outputs(fu_outputs), .fu_carry_out(fu_carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned fu_lat(input logic [1:0] mode);
        case (mode)
            2'd0:    return LAT_4X16;
            2'd1:    return LAT_2X32;
            2'd3:    return LAT_1X64;
            default: return 0;
        endcase
    endfunction

    // Lane k adds operand 2k to operand 2k+1; wider modes ripple carries across lanes
    function automatic logic [64:0] ref_add(input logic [1:0] mode, input ops_t o);
        logic [63:0] a, b;
        logic [64:0] r;
        logic [32:0] lo, hi;
        logic [16:0] l;
        a = {o[6], o[4], o[2], o[0]};
        b = {o[7], o[5], o[3], o[1]};
        r = '0;
        case (mode)
            2'd0: begin
                for (int k = 0; k < 4; k++) begin
                    l = {1'b0, a[16*k +: 16]} + {1'b0, b[16*k +: 16]};
                    r[16*k +: 16] = l[15:0];
                    if (k == 3) r[64] = l[16];
                end
            end
            2'd1: begin
                lo = {1'b0, a[31:0]} + {1'b0, b[31:0]};
                hi = {1'b0, a[63:32]} + {1'b0, b[63:32]};
                r  = {hi, lo[31:0]};
            end
            2'd3:    r = {1'b0, a} + {1'b0, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural FU: outputs are X until on_off has been high for LAT cycles
    int unsigned on_cnt;
    logic [64:0] fu_r;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         on_cnt <= 0;
        else if (fu_on_off) on_cnt <= on_cnt + 1;
        else                on_cnt <= 0;
    end
    always_comb begin
        fu_r         = ref_add(fu_config, fu_inputs);
        fu_outputs   = 'x;
        fu_carry_out = 1'bx;
        if (fu_on_off && fu_config != 2'd2 && on_cnt + 1 >= fu_lat(fu_config)) begin
            fu_outputs   = fu_r[63:0];
            fu_carry_out = fu_r[64];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops(output ops_t o);
        for (int k = 0; k < 8; k++) o[k] = WIDTH'($urandom);
    endtask

    // One op from a lone requester; hold = cycles of rsp backpressure
    task automatic run_op(input int id, input logic [1:0] mode, input ops_t ops,
                          input int hold, output logic [63:0] got_sum);
        int n, lat, on, other;
        logic [64:0] e;
        logic legal;
        legal = (mode != 2'd2);
        e     = legal ? ref_add(mode, ops) : 65'd0;
        other = (id + 1) % NUM_REQ;
        @(negedge clk);
        req_mode[id]     = mode;
        req_operands[id] = ops;
        req_valid[id]    = 1'b1;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", 64'(req_ready), 64'(1) << id);
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        lat = 1;
        on  = 0;
        while (rsp_valid !== 1'b1 && lat < 30) begin
            if (fu_on_off === 1'b1) on++;
            @(negedge clk); #1; lat++;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_latency", 64'(lat), legal ? 64'(fu_lat(mode) + 1) : 64'd1);
        chk("on_off_cycles", 64'(on), legal ? 64'(fu_lat(mode)) : 64'd0);
        chk("rsp_id", 64'(rsp_id), 64'(id));
        chk("rsp_sum", 64'(rsp_sum), e[63:0]);
        chk("rsp_carry", 64'(rsp_carry), 64'(e[64]));
        chk("rsp_err", 64'(rsp_err), legal ? 64'd0 : 64'd1);
        chk("rsp_on_off", 64'(fu_on_off), 64'd0);
        got_sum = rsp_sum;
        if (hold > 0) begin
            req_mode[other]  = 2'd0;
            req_valid[other] = 1'b1;
            #1;
        end
        for (int h = 0; h < hold; h++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_sum", 64'(rsp_sum), e[63:0]);
            chk("bp_on_off", 64'(fu_on_off), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        if (hold > 0) begin
            chk("next_accept", 64'(req_ready), 64'(1) << other);
            req_valid[other] = 1'b0;
            #1;
            chk("drop_before_grant", 64'(req_ready), 64'd0);
        end
    endtask

    initial begin
        ops_t        ops;
        ops_t        fops [NUM_REQ];
        logic [63:0] got;
        int          n, grants, last_t, exp_id;
        int          q[$];
        logic [1:0]  m;

        reset        = 1'b0;
        req_valid    = '1;
        req_mode     = '0;
        req_operands = '0;
        rsp_ready    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_flags", 64'({rsp_carry, rsp_err}), 64'd0);
        chk("rst_fu_inputs", fu_inputs[3:0], 64'd0);
        chk("rst_fu_cfg_on", 64'({fu_config, fu_on_off}), 64'd0);
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rsp_ready_idle_ignored", 64'(rsp_valid), 64'd0);

        for (int k = 0; k < 8; k++) ops[k] = WIDTH'(k + 1);
        run_op(0, 2'd0, ops, 0, got);
        chk("sum_4x16_const", got, 64'h000F_000B_0007_0003);

        ops    = '0;
        ops[0] = 16'hFFFF;
        ops[1] = 16'h0001;
        run_op(2, 2'd3, ops, 0, got);
        chk("sum_1x64_const", got, 64'h0000_0000_0001_0000);

        rand_ops(ops);
        run_op(1, 2'd2, ops, 0, got);
        chk("illegal_sum_const", got, 64'd0);

        rand_ops(ops);
        run_op(3, 2'd1, ops, 10, got);

        for (int t = 0; t < 16; t++) begin
            rand_ops(ops);
            if ((t % 4) == 1) begin
                ops[0] = 16'hFFFF; ops[1] = 16'hFFFF; ops[2] = 16'hFFFF; ops[3] = 16'h0000;
            end
            m = 2'($urandom_range(3, 0));
            run_op(int'($urandom_range(NUM_REQ - 1, 0)), m, ops,
                   int'($urandom_range(3, 0)), got);
        end

        // Reset during the first WAIT cycle of a 1x64 op abandons it
        rand_ops(ops);
        @(negedge clk);
        req_mode[2]     = 2'd3;
        req_operands[2] = ops;
        req_valid[2]    = 1'b1;
        #1;
        n = 0;
        while (req_ready[2] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("mid_grant", 64'(req_ready), 64'd4);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        chk("mid_on_before", 64'(fu_on_off), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_on_after", 64'(fu_on_off), 64'd0);
        chk("mid_valid_after", 64'(rsp_valid), 64'd0);
        chk("mid_fu_cfg", 64'(fu_config), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            chk("no_stale_rsp", 64'({rsp_valid, fu_on_off}), 64'd0);
        end

        // All requesters held valid: grants rotate from 0, one op per LAT+2 cycles
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            rand_ops(fops[i]);
            req_operands[i] = fops[i];
            req_mode[i]     = 2'd0;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        grants = 0; n = 0; last_t = -1; exp_id = 0;
        while (grants < 5 && n < 100) begin
            if (rsp_valid === 1'b1) begin
                chk("rr_rsp_id", 64'(rsp_id), 64'(q.pop_front()));
                chk("rr_rsp_sum", 64'(rsp_sum), ref_add(2'd0, fops[rsp_id])
                                                   & 65'h0_FFFF_FFFF_FFFF_FFFF);
            end
            if (req_ready !== '0) begin
                chk("rr_grant", 64'(req_ready), 64'(1) << exp_id);
                if (last_t >= 0) chk("rr_period", 64'(n - last_t), 64'(LAT_4X16 + 2));
                last_t = n;
                q.push_back(exp_id);
                exp_id = (exp_id + 1) % NUM_REQ;
                grants++;
            end
            @(negedge clk); #1; n++;
        end
        chk("rr_grant_count", 64'(grants), 64'd5);
        req_valid = '0;
        n = 0;
        while (q.size() > 0 && n < 30) begin
            if (rsp_valid === 1'b1) chk("rr_last_id", 64'(rsp_id), 64'(q.pop_front()));
            @(negedge clk); #1; n++;
        end
        chk("rr_drained", 64'(q.size()), 64'd0);
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
